keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter DEBOUNCE_TICKS, default 4, meaning consecutive stable scan ticks needed to accept a press or release; legal range 1..15.
REQ-002 CLK  input  1  system clock, 50 MHz; sole clock of the block.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 scan_clk  input  1  slow square wave from the clock divider (CLK domain); each rising edge is one scan tick.
REQ-005 row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to CLK.
REQ-006 col_n  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  accepted key, {row[1:0], col[1:0]}.
REQ-008 key_valid  output  1  one-CLK pulse per accepted key event.
REQ-009 key_held  output  1  high while an accepted key is considered pressed.

Function
REQ-010 row_n SHALL pass through a 2-flop synchronizer before any use.
REQ-011 scan_tick SHALL be high for exactly one CLK cycle per scan_clk rising edge (registered edge detect); all state actions below occur only in tick cycles.
REQ-012 FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
REQ-013 SCAN: on tick, if any synced row low, latch col and lowest-index low row, cnt=1, go DEBOUNCE; else advance column 0->1->2->3->0 (wrap).
REQ-014 DEBOUNCE: column frozen; on tick, latched row still low -> cnt+1; latched row high -> cnt=0, advance column, go SCAN.
REQ-015 DEBOUNCE: when cnt reaches DEBOUNCE_TICKS, update key_code, pulse key_valid, set key_held, cnt=0, go HELD; DEBOUNCE_TICKS=1 accepts on the tick after the entry tick.
REQ-016 HELD: on tick, latched row high -> cnt=1, go RELEASE; other rows/columns ignored.
REQ-017 RELEASE: on tick, latched row low -> cnt=0, back to HELD (no new key_valid); high -> cnt+1; at DEBOUNCE_TICKS clear key_held, cnt=0, advance column, go SCAN.
REQ-018 key_valid SHALL be registered: asserted in the CLK cycle after the accepting tick, for exactly one cycle.
REQ-019 key_code SHALL hold its value until the next accepted key.
REQ-020 Counters 4 bits wide, never wrap within legal parameter range.

Reset
REQ-021 On RST: col_n=4'b1110, key_code=0, key_valid=0, key_held=0, state SCAN, cnt=0, synchronizer flops=4'b1111, edge-detect flops=0.
REQ-022 RST SHALL take priority over a coincident scan_tick; reset mid-debounce or mid-held SHALL emit no key_valid.
REQ-023 First tick after reset SHALL NOT be generated merely from releasing RST while scan_clk is high (edge detect starts at 0, needs a low-to-high).

Configuration
REQ-024 Macro KEYPAD_AUTOREPEAT_EN defined: in HELD, key_valid pulses again (same key_code) every 16 ticks after the accepting tick while held.
REQ-025 Macro undefined: exactly one key_valid per press; repeat counter not instantiated.

Verification
REQ-026 Reset, no key, 8 ticks -> col_n sequence 1101,1011,0111,1110,1101,... ; key_valid never high.
REQ-027 Row 2 low while col 1 driven, held 4 ticks -> one key_valid, key_code=4'b1001, key_held=1, col_n frozen at 1101.
REQ-028 Row 2 low 2 ticks then bounces high -> no key_valid, scan resumes at col 2.
REQ-029 Accepted key released 2 ticks, re-pressed, then released 4 ticks -> no extra key_valid; key_held clears on 4th release tick.
REQ-030 Rows 1 and 3 low in col 0 -> key_code=4'b0100 (lowest row wins).
REQ-031 RST asserted in HELD -> next cycle all outputs at reset values; with KEYPAD_AUTOREPEAT_EN, key held 40 ticks -> 3 key_valid pulses.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row debounce, registered key events.
// Optional KEYPAD_AUTOREPEAT_EN macro adds a key_valid repeat every 16 ticks while a key is held.
module keypad_scanner #(
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       scan_clk,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [4:0] DB_TH = 5'(DEBOUNCE_TICKS);

  logic [3:0] row_s1_q, row_s1_d;
  logic [3:0] row_s2_q, row_s2_d;
  logic       scan_prev_q, scan_prev_d;
  logic       armed_q, armed_d;
  logic       tick_q, tick_d;
  state_t     state_q, state_d;
  logic [3:0] col_n_q, col_n_d;
  logic [1:0] row_idx_q, row_idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [3:0] rep_q, rep_d;
`endif

  logic       row_lat_low;
  logic [4:0] cnt_inc;
  logic       cnt_done;

  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] next_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  always_comb begin
    // Stage 0: row synchronizer and scan tick edge detect
    row_s1_d    = row_n;
    row_s2_d    = row_s1_q;
    scan_prev_d = scan_clk;
    // A tick requires a low level seen since reset, so releasing RST with scan_clk high is not an edge.
    armed_d     = armed_q | ~scan_clk;
    tick_d      = scan_clk & ~scan_prev_q & armed_q;

    state_d     = state_q;
    col_n_d     = col_n_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d       = rep_q;
`endif

    row_lat_low = ~row_s2_q[row_idx_q];
    cnt_inc     = {1'b0, cnt_q} + 5'd1;
    cnt_done    = (cnt_inc >= DB_TH);

    // Stage 1: scan FSM, acting only on tick cycles
    if (tick_q) begin
      case (state_q)
        SCAN: begin
          if (row_s2_q != 4'hF) begin
            row_idx_d = lowest_low(row_s2_q);
            cnt_d     = 4'd1;
            state_d   = DEBOUNCE;
          end else begin
            col_n_d = next_col(col_n_q);
          end
        end
        DEBOUNCE: begin
          if (row_lat_low) begin
            if (cnt_done) begin
              key_code_d  = {row_idx_q, col_index(col_n_q)};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = 4'd0;
              state_d     = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d       = 4'd0;
`endif
            end else begin
              cnt_d = cnt_inc[3:0];
            end
          end else begin
            cnt_d   = 4'd0;
            col_n_d = next_col(col_n_q);
            state_d = SCAN;
          end
        end
        HELD: begin
          if (!row_lat_low) begin
            cnt_d   = 4'd1;
            state_d = RELEASE;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else begin
            // Wrap of the 4-bit counter marks 16 held ticks since the last event.
            rep_d = rep_q + 4'd1;
            if (rep_q == 4'hF) key_valid_d = 1'b1;
          end
`endif
        end
        RELEASE: begin
          if (row_lat_low) begin
            cnt_d   = 4'd0;
            state_d = HELD;
          end else if (cnt_done) begin
            key_held_d = 1'b0;
            cnt_d      = 4'd0;
            col_n_d    = next_col(col_n_q);
            state_d    = SCAN;
          end else begin
            cnt_d = cnt_inc[3:0];
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // Stage 2: state and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      scan_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      tick_q      <= 1'b0;
      state_q     <= SCAN;
      col_n_q     <= 4'b1110;
      row_idx_q   <= 2'd0;
      cnt_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= 4'd0;
`endif
    end else begin
      row_s1_q    <= row_s1_d;
      row_s2_q    <= row_s2_d;
      scan_prev_q <= scan_prev_d;
      armed_q     <= armed_d;
      tick_q      <= tick_d;
      state_q     <= state_d;
      col_n_q     <= col_n_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, scan ticks, key_code scoreboard.
module tb_keypad_scanner;

  logic       CLK = 1'b0;
  logic       RST;
  logic       scan_clk;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] keys;
  logic [3:0]  exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_kv  = 0;
  logic        kv_prev = 1'b0;
  int          exp_col = 0;
  int          kv_base;
  int          kv_exp;

  keypad_scanner #(.DEBOUNCE_TICKS(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .scan_clk (scan_clk),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #10 CLK = ~CLK;

  // Matrix: a pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] col_pat(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  always @(negedge CLK) begin
    if (key_valid) begin
      n_kv++;
      if (exp_q.size() == 0) chk("kv_unexpected", 32'(key_valid), 32'd0);
      else                   chk("key_code_sb", 32'(key_code), 32'(exp_q.pop_front()));
      if (kv_prev) chk("kv_width", 32'(kv_prev), 32'd0);
    end
    kv_prev = key_valid;
  end

  task automatic do_tick();
    @(negedge CLK) scan_clk = 1'b1;
    repeat (8) @(negedge CLK);
    scan_clk = 1'b0;
    repeat (8) @(negedge CLK);
  endtask

  task automatic scan_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do_tick();
      exp_col = (exp_col + 1) % 4;
    end
  endtask

  initial begin
    RST = 1'b1; scan_clk = 1'b1; keys = 16'h0;
    repeat (3) @(negedge CLK);
    chk("rst_col_n", 32'(col_n), 32'(4'b1110));
    chk("rst_key_code", 32'(key_code), 32'd0);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_key_held", 32'(key_held), 32'd0);
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    chk("no_tick_on_rst_release", 32'(col_n), 32'(4'b1110));
    scan_clk = 1'b0;
    repeat (4) @(negedge CLK);

    // Idle scanning
    for (int i = 0; i < 8; i++) begin
      scan_ticks(1);
      chk("idle_col_n", 32'(col_n), 32'(col_pat(exp_col)));
    end
    chk("idle_no_kv", 32'(n_kv), 32'd0);

    // Press row 2 / col 1
    keys[2*4+1] = 1'b1;
    exp_q.push_back(4'b1001);
    scan_ticks(1);
    chk("press_col1", 32'(col_n), 32'(4'b1101));
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk("debounce_held", 32'(key_held), 32'd0);
    end
    chk("debounce_no_kv", 32'(n_kv), 32'd0);
    do_tick();
    chk("accept_kv", 32'(n_kv), 32'd1);
    chk("accept_held", 32'(key_held), 32'd1);
    chk("accept_code", 32'(key_code), 32'(4'b1001));
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk("held_col_frozen", 32'(col_n), 32'(4'b1101));
    end
    chk("held_single_kv", 32'(n_kv), 32'd1);

    // Short release, re-press, full release
    keys = 16'h0;
    do_tick(); do_tick();
    chk("short_rel_held", 32'(key_held), 32'd1);
    keys[2*4+1] = 1'b1;
    do_tick();
    chk("repress_held", 32'(key_held), 32'd1);
    keys = 16'h0;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      chk("release_held", 32'(key_held), 32'd1);
    end
    do_tick();
    exp_col = 2;
    chk("release_cleared", 32'(key_held), 32'd0);
    chk("release_col2", 32'(col_n), 32'(col_pat(exp_col)));
    chk("release_no_kv", 32'(n_kv), 32'd1);

    // Bounce: press seen for 2 ticks then gone
    scan_ticks(3);
    chk("bounce_at_col1", 32'(col_n), 32'(4'b1101));
    keys[2*4+1] = 1'b1;
    do_tick(); do_tick();
    keys = 16'h0;
    do_tick();
    exp_col = 2;
    chk("bounce_resume_col2", 32'(col_n), 32'(4'b1011));
    chk("bounce_held", 32'(key_held), 32'd0);
    chk("bounce_no_kv", 32'(n_kv), 32'd1);

    // Two rows low on column 0: lowest row wins
    keys[1*4+0] = 1'b1;
    keys[3*4+0] = 1'b1;
    exp_q.push_back(4'b0100);
    scan_ticks(2);
    chk("multi_at_col0", 32'(col_n), 32'(4'b1110));
    repeat (4) do_tick();
    chk("multi_kv", 32'(n_kv), 32'd2);
    chk("multi_code", 32'(key_code), 32'(4'b0100));
    chk("multi_held", 32'(key_held), 32'd1);

    // Reset while held
    @(negedge CLK) RST = 1'b1;
    keys = 16'h0;
    @(negedge CLK);
    chk("rst_held_col_n", 32'(col_n), 32'(4'b1110));
    chk("rst_held_code", 32'(key_code), 32'd0);
    chk("rst_held_kv", 32'(key_valid), 32'd0);
    chk("rst_held_held", 32'(key_held), 32'd0);
    RST = 1'b0;
    exp_col = 0;
    repeat (4) @(negedge CLK);

    // Long hold: 40 ticks on key (0,0)
    kv_base = n_kv;
    keys[0] = 1'b1;
    exp_q.push_back(4'b0000);
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    kv_exp = 3;
`else
    kv_exp = 1;
`endif
    repeat (40) do_tick();
    chk("long_hold_kv", 32'(n_kv - kv_base), 32'(kv_exp));
    chk("long_hold_held", 32'(key_held), 32'd1);
    keys = 16'h0;
    repeat (4) do_tick();
    chk("long_release_held", 32'(key_held), 32'd0);

    repeat (4) @(negedge CLK);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
